// File: rtl/out_pixel_writer.sv
// Buffers signed pixel results, clamps them to 0..255 and writes them to sequential memory addresses.
// Writes one cycle after accept into an empty FIFO; res_ready drops when the FIFO is full or NUM_PIX results are taken.
module out_pixel_writer #(
  parameter int NUM_PIX    = 76800,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              res_valid,
  input  logic [31:0]       res_data,
  output logic              res_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] sat_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]       DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   NUM_PIX_C = (ADDR_W+1)'(NUM_PIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       cnt, cnt_n;
  logic [ADDR_W:0]   acc, acc_n;
  logic [ADDR_W-1:0] wptr;
  logic              push, pop, arm;
  logic [31:0]       head;
  logic [7:0]        pix;
  logic              clamped;

  always_comb begin
    state_n = state;
    arm     = 1'b0;
    push    = res_valid && res_ready;
    pop     = (state == RUN) && (cnt != '0);
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        arm     = 1'b1;
      end
      RUN:  if (pop && (wptr == LAST_ADDR)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = arm ? '0 : cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    acc_n = arm ? '0 : acc + {{ADDR_W{1'b0}}, push};
  end

  always_comb begin
    head    = fifo_mem[rd_ptr];
    clamped = 1'b1;
    if (head[31]) begin
      pix = 8'h00;
    end else if (head[30:8] != '0) begin
      pix = 8'hFF;
    end else begin
      pix     = head[7:0];
      clamped = 1'b0;
    end
  end

  // Storage carries no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      acc        <= '0;
      wptr       <= '0;
      res_ready  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sat_count  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      // Registered from next-cycle occupancy so a full FIFO blocks even when a pop is in flight.
      res_ready  <= (state_n == RUN) && (cnt_n != DEPTH_C) && (acc_n < NUM_PIX_C);
      busy       <= (state_n == RUN);
      frame_done <= (state == DONE);
      mem_we     <= pop;
      if (arm) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        wptr      <= '0;
        sat_count <= '0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        mem_addr  <= wptr;
        mem_wdata <= pix;
        wptr      <= wptr + ADDR_W'(1);
        if (clamped && !(&sat_count)) sat_count <= sat_count + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_out_pixel_writer.sv
// Randomized bench for out_pixel_writer: a queue scoreboard with a spec-level clamp model checks every write.
module tb_out_pixel_writer;
  localparam int NUM_PIX = 76800;
  localparam int ADDR_W  = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              res_valid = 1'b0;
  logic [31:0]       res_data = '0;
  logic              res_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W-1:0] sat_count;

  out_pixel_writer #(.NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .frame_done(frame_done), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  logic [7:0]  wlog[$];
  logic pushed_last = 1'b0;
  int exp_addr = 0;
  int sat_exp = 0;
  int wr_count = 0;
  int acc_total = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int first_acc_cyc = -1;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [8:0] clamp_ref(input logic [31:0] d);
    int v;
    v = $signed(d);
    if (v < 0) return 9'h100;
    if (v > 255) return 9'h1FF;
    return {1'b0, d[7:0]};
  endfunction

  // One cycle: check the writes the model predicts, then drive the next inputs.
  task automatic step(input logic v, input logic [31:0] d, input logic st, output logic acc);
    logic [8:0] r;
    logic exp_we;
    @(negedge clk);
    cyc++;
    exp_we = (q.size() > (pushed_last ? 1 : 0));
    check("mem_we", 64'(mem_we), 64'(exp_we));
    if (mem_we && q.size() > 0) begin
      r = clamp_ref(q.pop_front());
      check("mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(r[7:0]));
      if (r[8]) sat_exp++;
      wlog.push_back(mem_wdata);
      exp_addr++;
      wr_count++;
    end
    check("sat_count", 64'(sat_count), 64'(sat_exp));
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    res_valid = v;
    res_data  = d;
    start     = st;
    acc = v && res_ready;
    if (acc) begin
      q.push_back(d);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      acc_total++;
    end
    pushed_last = acc;
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; res_valid = 1'b1; start = 1'b1; res_data = 32'h55;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_outs", 64'({res_ready, mem_we, mem_addr, mem_wdata, busy, frame_done, sat_count}), 64'd0);
    end
    rst_n = 1'b1; res_valid = 1'b0; start = 1'b0;
    q.delete(); wlog.delete();
    pushed_last = 1'b0; exp_addr = 0; sat_exp = 0; wr_count = 0;
    acc_total = 0; fd_count = 0; first_acc_cyc = -1;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 255));
      1: return -32'($urandom_range(1, 1000));
      2: return 32'($urandom_range(256, 100000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic a;
    logic [31:0] cvals[6];
    logic [7:0]  cexp[6];
    int idx, frame_acc, guard;
    cvals = '{32'hFFFFFFFF, 32'h0, 32'd255, 32'd256, 32'h7FFFFFFF, 32'h80000000};
    cexp  = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0};

    hold_reset(3);

    // Clamp corners
    step(1'b0, 32'h0, 1'b1, a);
    idx = 0; guard = 0;
    while (idx < 6 && guard < 100) begin
      step(1'b1, cvals[idx], 1'b0, a);
      if (a) idx++;
      guard++;
    end
    check("clamp_accepts", 64'(idx), 64'd6);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, a);
    check("clamp_writes", 64'(wlog.size()), 64'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) check("clamp_value", 64'(wlog[i]), 64'(cexp[i]));
    check("clamp_sat", 64'(sat_count), 64'd4);
    check("busy_run", 64'(busy), 64'd1);

    // Random bubbles plus stray start pulses, then reset mid-frame
    guard = 0;
    while (wr_count < 1000 && guard < 20000) begin
      step(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 7) == 0), a);
      guard++;
    end
    check("bubble_writes", 64'(wr_count >= 1000), 64'd1);
    check("bubble_addr", 64'(exp_addr), 64'(wr_count));
    step(1'b1, 32'd77, 1'b0, a);
    hold_reset(2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd99, 1'b0, a);
      check("idle_ready", 64'(res_ready), 64'd0);
    end
    step(1'b1, 32'd99, 1'b0, a);

    // Full frame followed by over-delivery
    q.delete(); pushed_last = 1'b0; acc_total = 0; first_acc_cyc = -1;
    step(1'b0, 32'h0, 1'b1, a);
    check("restart_sat", 64'(sat_count), 64'd0);
    frame_acc = 0; guard = 0;
    while (fd_count == 0 && guard < NUM_PIX + 200) begin
      step(1'b1, 32'(frame_acc % 256), 1'b0, a);
      if (a) frame_acc++;
      guard++;
    end
    check("frame_timeout", 64'(fd_count), 64'd1);
    check("frame_latency", 64'(fd_cyc - first_acc_cyc), 64'(NUM_PIX + 2));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hFFFF, 1'b0, a);
      check("over_ready", 64'(res_ready), 64'd0);
    end
    check("frame_pulses", 64'(fd_count), 64'd1);
    check("frame_accepts", 64'(acc_total), 64'(NUM_PIX));
    check("frame_writes", 64'(wr_count), 64'(NUM_PIX));
    check("frame_end_addr", 64'(exp_addr), 64'(NUM_PIX));
    check("frame_sat", 64'(sat_count), 64'd0);
    check("frame_busy", 64'(busy), 64'd0);
    check("frame_leftover", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
